// File: rtl/psum_row_buf_if.sv
// Bundles the signals of the partial-sum row buffer into one interface.
// It covers the psum input stream, the requantise configuration, the
// quantised output stream and the error flag. The design side is "slave"
// and the producer/consumer side is "master".
interface psum_row_buf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 20,
  parameter int BLK_WIDTH  = 4
);
  logic                          CNVPSB_Vld;
  logic signed [PSUM_WIDTH-1:0]  CNVPSB_Psum;
  logic                          CNVPSB_FnhRow;
  logic                          PSBCNV_Rdy;
  logic        [BLK_WIDTH-1:0]   CFG_NumBlk;
  logic        [4:0]             CFG_Shift;
  logic                          CFG_Relu;
  logic                          PSBOUT_Vld;
  logic signed [DATA_WIDTH-1:0]  PSBOUT_Dat;
  logic                          PSBOUT_Rdy;
  logic                          PSBOUT_Done;
  logic                          PSBERR_Flg;

  modport master (
    output CNVPSB_Vld, CNVPSB_Psum, CNVPSB_FnhRow,
    output CFG_NumBlk, CFG_Shift, CFG_Relu,
    output PSBOUT_Rdy,
    input  PSBCNV_Rdy, PSBOUT_Vld, PSBOUT_Dat, PSBOUT_Done, PSBERR_Flg
  );

  modport slave (
    input  CNVPSB_Vld, CNVPSB_Psum, CNVPSB_FnhRow,
    input  CFG_NumBlk, CFG_Shift, CFG_Relu,
    input  PSBOUT_Rdy,
    output PSBCNV_Rdy, PSBOUT_Vld, PSBOUT_Dat, PSBOUT_Done, PSBERR_Flg
  );
endinterface

// File: rtl/psum_row_buf.sv
// Partial-sum row buffer. It accumulates one output row of psums across
// CFG_NumBlk+1 channel blocks. After the final block it requantises each
// entry (shift, round half up, optional ReLU, saturate) and streams the
// row out over a valid/ready handshake.
module psum_row_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 20,
  parameter int LENPSUM    = 16,
  parameter int BLK_WIDTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  psum_row_buf_if.slave bus
);

  localparam int AW  = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
  localparam int CW  = $clog2(LENPSUM + 1);
  localparam int PW1 = PSUM_WIDTH + 1;
  localparam logic [CW-1:0] LEN_C = CW'(LENPSUM);

  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] DAT_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DAT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [PW1-1:0]        Q_MAX    = PW1'(DAT_MAX);
  localparam logic signed [PW1-1:0]        Q_MIN    = PW1'(DAT_MIN);
  localparam logic signed [PW1-1:0]        ONE      = PW1'(1);

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  // Accumulation add, clamped at the signed psum limits.
  function automatic logic signed [PSUM_WIDTH-1:0] sat_add(
    input logic signed [PSUM_WIDTH-1:0] a,
    input logic signed [PSUM_WIDTH-1:0] b
  );
    logic signed [PW1-1:0] s;
    s = PW1'(a) + PW1'(b);
    if (s > PW1'(PSUM_MAX))      sat_add = PSUM_MAX;
    else if (s < PW1'(PSUM_MIN)) sat_add = PSUM_MIN;
    else                         sat_add = s[PSUM_WIDTH-1:0];
  endfunction

  // Shift with round-half-up at one bit of headroom, then ReLU and saturate.
  function automatic logic signed [DATA_WIDTH-1:0] requant(
    input logic signed [PSUM_WIDTH-1:0] x,
    input logic        [4:0]            sh,
    input logic                         relu
  );
    logic signed [PW1-1:0] rnd;
    logic signed [PW1-1:0] y;
    rnd = '0;
    if (sh != 5'd0 && sh <= 5'(PSUM_WIDTH)) rnd = ONE <<< (sh - 5'd1);
    y = (PW1'(x) + rnd) >>> sh;
    if (relu && y < 0) y = '0;
    if (y > Q_MAX)      requant = DAT_MAX;
    else if (y < Q_MIN) requant = DAT_MIN;
    else                requant = y[DATA_WIDTH-1:0];
  endfunction

  state_t                        state, state_nxt;
  logic        [CW-1:0]          wr_addr;
  logic        [CW-1:0]          rd_addr;
  logic        [CW-1:0]          row_len;
  logic        [BLK_WIDTH-1:0]   blk_cnt;
  logic        [BLK_WIDTH-1:0]   num_blk_lat;
  logic        [4:0]             shift_lat;
  logic                          relu_lat;
  logic                          err_flg;
  logic                          vld_p1;
  logic signed [DATA_WIDTH-1:0]  dat_p1;
  logic                          done_p1;
  logic signed [PSUM_WIDTH-1:0]  mem [LENPSUM];

  logic                          wr_en;
  logic                          fnh;
  logic                          row_start;
  logic                          last_blk;
  logic        [BLK_WIDTH-1:0]   num_blk_eff;
  logic signed [PSUM_WIDTH-1:0]  wr_val;
  logic                          xfer;
  logic                          slot_free;
  logic                          rd_last;

  // Until the first write of a row lands, the live block count is used.
  assign row_start   = (blk_cnt == '0) && (wr_addr == '0);
  assign num_blk_eff = row_start ? bus.CFG_NumBlk : num_blk_lat;
  assign last_blk    = (blk_cnt == num_blk_eff);
  assign wr_en       = bus.CNVPSB_Vld && (state == ACC) && (wr_addr != LEN_C);
  assign fnh         = bus.CNVPSB_FnhRow && (state == ACC);
  assign wr_val      = (blk_cnt == '0) ? bus.CNVPSB_Psum
                                       : sat_add(mem[wr_addr[AW-1:0]], bus.CNVPSB_Psum);

  assign xfer        = vld_p1 && bus.PSBOUT_Rdy;
  assign slot_free   = !vld_p1 || xfer;
  assign rd_last     = (rd_addr == row_len);

  assign bus.PSBCNV_Rdy  = (state == ACC);
  assign bus.PSBOUT_Vld  = vld_p1;
  assign bus.PSBOUT_Dat  = dat_p1;
  assign bus.PSBOUT_Done = done_p1;
  assign bus.PSBERR_Flg  = err_flg;

  // Next-state: final FnhRow starts the drain; the last transfer ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (fnh && last_blk) state_nxt = DRAIN;
      DRAIN:   if (slot_free && rd_last) state_nxt = DONE;
      DONE:    state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Row buffer storage; contents are only meaningful below row_len.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW-1:0]] <= wr_val;
  end

  // --- stage p1: control state, addresses and the registered output word ---
  // Control, counters and output registers; reset discards any partial row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACC;
      wr_addr     <= '0;
      rd_addr     <= '0;
      row_len     <= '0;
      blk_cnt     <= '0;
      num_blk_lat <= '0;
      shift_lat   <= '0;
      relu_lat    <= 1'b0;
      err_flg     <= 1'b0;
      vld_p1      <= 1'b0;
      dat_p1      <= '0;
      done_p1     <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_p1 <= (state_nxt == DONE);
      err_flg <= err_flg | (bus.CNVPSB_Vld && ((state != ACC) || (wr_addr == LEN_C)));

      if (state == ACC) begin
        if (row_start) num_blk_lat <= bus.CFG_NumBlk;
        if (wr_en)     wr_addr     <= wr_addr + 1'b1;
        if (fnh) begin
          wr_addr <= '0;
          if (blk_cnt == '0) row_len <= wr_addr + CW'(wr_en);
          if (last_blk) begin
            blk_cnt   <= '0;
            rd_addr   <= '0;
            shift_lat <= bus.CFG_Shift;
            relu_lat  <= bus.CFG_Relu;
          end else begin
            blk_cnt <= blk_cnt + 1'b1;
          end
        end
      end else if (state == DRAIN) begin
        if (slot_free) begin
          if (!rd_last) begin
            vld_p1  <= 1'b1;
            dat_p1  <= requant(mem[rd_addr[AW-1:0]], shift_lat, relu_lat);
            rd_addr <= rd_addr + 1'b1;
          end else begin
            vld_p1 <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_row_buf.sv
// Bench for psum_row_buf: scenario tasks drive rows and push the expected
// quantised outputs into a queue; a negedge monitor pops and compares on
// every output transfer.
module tb_psum_row_buf;

  localparam int DATA_WIDTH = 8;
  localparam int PSUM_WIDTH = 20;
  localparam int LENPSUM    = 16;
  localparam int BLK_WIDTH  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_q[$];
  int   mon_got;
  int   mon_exp;

  psum_row_buf_if #(.DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH), .BLK_WIDTH(BLK_WIDTH)) bus ();

  psum_row_buf #(
    .DATA_WIDTH(DATA_WIDTH), .PSUM_WIDTH(PSUM_WIDTH),
    .LENPSUM(LENPSUM), .BLK_WIDTH(BLK_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.PSBOUT_Vld === 1'b1 && bus.PSBOUT_Rdy === 1'b1) begin
      checks++;
      mon_got = bus.PSBOUT_Dat;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0d, queue empty", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL out_dat: got %0d expected %0d", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int psum, input bit fnh);
    bus.CNVPSB_Vld    = 1'b1;
    bus.CNVPSB_Psum   = PSUM_WIDTH'(psum);
    bus.CNVPSB_FnhRow = fnh;
    tick();
    bus.CNVPSB_Vld    = 1'b0;
    bus.CNVPSB_FnhRow = 1'b0;
  endtask

  task automatic set_cfg(input int nblk, input int sh, input bit relu);
    bus.CFG_NumBlk = BLK_WIDTH'(nblk);
    bus.CFG_Shift  = 5'(sh);
    bus.CFG_Relu   = relu;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.PSBOUT_Done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (bus.PSBOUT_Done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: no Done pulse within 200 cycles", name);
    end
    tick();
    checks++;
    if (bus.PSBOUT_Done !== 1'b0 || bus.PSBCNV_Rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_after_done: got done=%0b rdy=%0b expected done=0 rdy=1",
               name, bus.PSBOUT_Done, bus.PSBCNV_Rdy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d outputs missing expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.PSBCNV_Rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b expected 1", bus.PSBCNV_Rdy); end
    checks++;
    if (bus.PSBOUT_Vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", bus.PSBOUT_Vld); end
    checks++;
    if (bus.PSBOUT_Dat !== 8'sd0) begin errors++; $display("FAIL reset_dat: got %0d expected 0", bus.PSBOUT_Dat); end
    checks++;
    if (bus.PSBOUT_Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus.PSBOUT_Done); end
    checks++;
    if (bus.PSBERR_Flg !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", bus.PSBERR_Flg); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_cfg(0, 2, 1'b0);
    bus.PSBOUT_Rdy = 1'b1;
    exp_q.push_back(25); exp_q.push_back(50); exp_q.push_back(-12); exp_q.push_back(75);
    send(100, 1'b0); send(200, 1'b0); send(-50, 1'b0); send(300, 1'b1);
    checks++;
    if (bus.PSBCNV_Rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy_drain: got %0b expected 0", bus.PSBCNV_Rdy); end
    tick();
    checks++;
    if (bus.PSBOUT_Vld !== 1'b1 || bus.PSBOUT_Dat !== 8'sd25) begin
      errors++;
      $display("FAIL basic_first_out: got vld=%0b dat=%0d expected vld=1 dat=25", bus.PSBOUT_Vld, bus.PSBOUT_Dat);
    end
    wait_done("basic");
  endtask

  task automatic test_multiblk();
    set_cfg(2, 0, 1'b0);
    bus.PSBOUT_Rdy = 1'b1;
    exp_q.push_back(90); exp_q.push_back(120);
    send(10, 1'b0); send(20, 1'b1);
    send(30, 1'b0); send(40, 1'b1);
    checks++;
    if (bus.PSBCNV_Rdy !== 1'b1) begin errors++; $display("FAIL multiblk_rdy_mid: got %0b expected 1", bus.PSBCNV_Rdy); end
    send(50, 1'b0); send(60, 1'b1);
    checks++;
    if (bus.PSBCNV_Rdy !== 1'b0) begin errors++; $display("FAIL multiblk_rdy_drain: got %0b expected 0", bus.PSBCNV_Rdy); end
    wait_done("multiblk");
  endtask

  task automatic test_saturate();
    set_cfg(0, 0, 1'b0);
    bus.PSBOUT_Rdy = 1'b1;
    exp_q.push_back(127); exp_q.push_back(-128); exp_q.push_back(-5);
    send(1000, 1'b0); send(-1000, 1'b0); send(-5, 1'b1);
    wait_done("sat_norelu");
    set_cfg(0, 0, 1'b1);
    exp_q.push_back(127); exp_q.push_back(0); exp_q.push_back(0);
    send(1000, 1'b0); send(-1000, 1'b0); send(-5, 1'b1);
    wait_done("sat_relu");
  endtask

  task automatic test_back_pressure();
    set_cfg(0, 0, 1'b0);
    bus.PSBOUT_Rdy = 1'b0;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.PSBOUT_Vld !== 1'b1 || bus.PSBOUT_Dat !== 8'sd1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%0b dat=%0d expected vld=1 dat=1", i, bus.PSBOUT_Vld, bus.PSBOUT_Dat);
      end
      if (i < 2) tick();
    end
    bus.PSBOUT_Rdy = 1'b1;
    wait_done("backpressure");
  endtask

  task automatic test_overflow();
    set_cfg(0, 0, 1'b0);
    bus.PSBOUT_Rdy = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(i * 5 - 37);
    for (int i = 0; i < 16; i++) send(i * 5 - 37, 1'b0);
    checks++;
    if (bus.PSBERR_Flg !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %0b expected 0", bus.PSBERR_Flg); end
    send(99, 1'b1);
    checks++;
    if (bus.PSBERR_Flg !== 1'b1) begin errors++; $display("FAIL ovf_err_set: got %0b expected 1", bus.PSBERR_Flg); end
    wait_done("overflow");
    checks++;
    if (bus.PSBERR_Flg !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %0b expected 1", bus.PSBERR_Flg); end
  endtask

  task automatic test_reset_mid_drain();
    set_cfg(0, 0, 1'b0);
    bus.PSBOUT_Rdy = 1'b1;
    exp_q.push_back(10);
    send(10, 1'b0); send(20, 1'b0); send(30, 1'b0); send(40, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.PSBOUT_Vld !== 1'b0) begin errors++; $display("FAIL rst_mid_vld: got %0b expected 0", bus.PSBOUT_Vld); end
    checks++;
    if (bus.PSBCNV_Rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy: got %0b expected 1", bus.PSBCNV_Rdy); end
    checks++;
    if (bus.PSBERR_Flg !== 1'b0) begin errors++; $display("FAIL rst_mid_err: got %0b expected 0", bus.PSBERR_Flg); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rst_mid_count: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(7);
    send(7, 1'b1);
    wait_done("rst_next_row");
  endtask

  task automatic test_drain_write_err();
    set_cfg(0, 0, 1'b0);
    bus.PSBOUT_Rdy = 1'b1;
    exp_q.push_back(5);
    send(5, 1'b1);
    bus.CNVPSB_Vld  = 1'b1;
    bus.CNVPSB_Psum = PSUM_WIDTH'(77);
    tick();
    bus.CNVPSB_Vld  = 1'b0;
    checks++;
    if (bus.PSBERR_Flg !== 1'b1) begin errors++; $display("FAIL drain_write_err: got %0b expected 1", bus.PSBERR_Flg); end
    wait_done("drain_write");
  endtask

  task automatic test_sat_add();
    set_cfg(1, 13, 1'b0);
    bus.PSBOUT_Rdy = 1'b1;
    exp_q.push_back(64);
    send(524287, 1'b1); send(1, 1'b1);
    wait_done("sat_add_pos");
    exp_q.push_back(-64);
    send(-524288, 1'b1); send(-1, 1'b1);
    wait_done("sat_add_neg");
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    bus.CNVPSB_Vld    = 1'b0;
    bus.CNVPSB_Psum   = '0;
    bus.CNVPSB_FnhRow = 1'b0;
    bus.PSBOUT_Rdy    = 1'b0;
    set_cfg(0, 0, 1'b0);
    test_reset();
    test_basic();
    test_multiblk();
    test_saturate();
    test_back_pressure();
    test_overflow();
    test_reset_mid_drain();
    test_drain_write_err();
    test_sat_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
